// File: rtl/bit_sequencer_if.sv
// Handshake bundle between the operand/control side and the bit sequencer.
// The master issues start/operand and accepts bits; the slave is the sequencer.
interface bit_sequencer_if #(
    parameter int WIDTH = 16
);
    localparam int IDXW = $clog2(WIDTH);

    logic            start;
    logic [WIDTH-1:0] operand;
    logic            bit_ready;
    logic            bit_valid;
    logic            bit_out;
    logic [IDXW-1:0] bit_idx;
    logic            last;
    logic            busy;
    logic            done;

    modport master (
        output start, operand, bit_ready,
        input  bit_valid, bit_out, bit_idx, last, busy, done
    );

    modport slave (
        input  start, operand, bit_ready,
        output bit_valid, bit_out, bit_idx, last, busy, done
    );
endinterface

// File: rtl/bit_sequencer.sv
// Captures an operand on start and streams it out one bit per accepted beat,
// LSB- or MSB-first, with an optional early exit once no set bits remain.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// RUN   | presenting shadow[idx]; advance on bit_valid & bit_ready
// DONE  | single-cycle done pulse, then back to IDLE unconditionally
module bit_sequencer #(
    parameter int WIDTH      = 16,
    parameter int IDXW       = $clog2(WIDTH),
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bit_sequencer_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDXW-1:0] IDX_TOP   = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_FIRST = MSB_FIRST ? IDX_TOP : '0;
    localparam logic [IDXW-1:0] IDX_LAST  = MSB_FIRST ? '0 : IDX_TOP;
    // Early exit only makes sense when scanning upward.
    localparam bit EARLY = EARLY_EXIT && !MSB_FIRST;

    logic [1:0]       state;
    logic [WIDTH-1:0] shadow;
    logic [IDXW-1:0]  idx;
    logic             in_run;
    logic             hi_zero;
    logic             last_int;

    assign in_run   = (state == ST_RUN);
    assign hi_zero  = ((shadow >> idx) >> 1) == '0;
    assign last_int = in_run && ((idx == IDX_LAST) || (EARLY && hi_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            shadow <= '0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        shadow <= bus.operand;
                        idx    <= IDX_FIRST;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.bit_ready) begin
                        if (last_int)
                            state <= ST_DONE;
                        else if (MSB_FIRST)
                            idx <= idx - IDXW'(1);
                        else
                            idx <= idx + IDXW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Everything below depends on registers only, never on inputs.
    assign bus.bit_valid = in_run;
    assign bus.bit_out   = in_run & shadow[idx];
    assign bus.bit_idx   = in_run ? idx : '0;
    assign bus.last      = last_int;
    assign bus.busy      = in_run || (state == ST_DONE);
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_bit_sequencer.sv
// Directed bench for bit_sequencer: LSB-first, MSB-first and early-exit
// instances share a clock; one is selected per scan.
module tb_bit_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] operand;
    logic        bit_ready;
    int          sel;

    int n_vec = 0;
    int n_err = 0;

    bit_sequencer_if #(.WIDTH(16)) if_lsb ();
    bit_sequencer_if #(.WIDTH(16)) if_msb ();
    bit_sequencer_if #(.WIDTH(16)) if_ee  ();

    bit_sequencer #(.WIDTH(16), .MSB_FIRST(1'b0), .EARLY_EXIT(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_lsb));
    bit_sequencer #(.WIDTH(16), .MSB_FIRST(1'b1), .EARLY_EXIT(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(if_msb));
    bit_sequencer #(.WIDTH(16), .MSB_FIRST(1'b0), .EARLY_EXIT(1'b1)) u_ee  (.clk(clk), .rst(rst), .bus(if_ee));

    assign if_lsb.start     = start && (sel == 0);
    assign if_msb.start     = start && (sel == 1);
    assign if_ee.start      = start && (sel == 2);
    assign if_lsb.operand   = operand;
    assign if_msb.operand   = operand;
    assign if_ee.operand    = operand;
    assign if_lsb.bit_ready = bit_ready;
    assign if_msb.bit_ready = bit_ready;
    assign if_ee.bit_ready  = bit_ready;

    logic       o_valid, o_out, o_last, o_busy, o_done;
    logic [3:0] o_idx;

    always_comb begin
        o_valid = if_lsb.bit_valid;
        o_out   = if_lsb.bit_out;
        o_idx   = if_lsb.bit_idx;
        o_last  = if_lsb.last;
        o_busy  = if_lsb.busy;
        o_done  = if_lsb.done;
        if (sel == 1) begin
            o_valid = if_msb.bit_valid;
            o_out   = if_msb.bit_out;
            o_idx   = if_msb.bit_idx;
            o_last  = if_msb.last;
            o_busy  = if_msb.busy;
            o_done  = if_msb.done;
        end else if (sel == 2) begin
            o_valid = if_ee.bit_valid;
            o_out   = if_ee.bit_out;
            o_idx   = if_ee.bit_idx;
            o_last  = if_ee.last;
            o_busy  = if_ee.busy;
            o_done  = if_ee.done;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Runs one full scan on DUT 's' starting at posedge+1; stalls 3 cycles at
    // index stall_at; poke pulses start with another operand in RUN and DONE.
    task automatic run_scan(input int s, input logic [15:0] op, input int stall_at,
                            input bit poke, output int beats, output logic [15:0] rx);
        int n, hi, e;
        hi = 0;
        for (int i = 0; i < 16; i++) if (op[i]) hi = i;
        n     = (s == 2) ? hi + 1 : 16;
        beats = 0;
        rx    = '0;
        sel = s; operand = op; bit_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            e = (s == 1) ? 15 - k : k;
            chk($sformatf("valid[%0d]", k), o_valid, 1);
            chk($sformatf("idx[%0d]", k), o_idx, e);
            chk($sformatf("bit[%0d]", k), o_out, op[e]);
            chk($sformatf("last[%0d]", k), o_last, (k == n - 1) ? 1 : 0);
            chk($sformatf("busy[%0d]", k), o_busy, 1);
            if (o_valid) begin
                beats++;
                rx[o_idx] = o_out;
            end
            if (e == stall_at) begin
                bit_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("stall_valid", o_valid, 1);
                    chk("stall_idx", o_idx, e);
                    chk("stall_bit", o_out, op[e]);
                end
                bit_ready = 1'b1;
            end
            if (poke && k == 3) begin
                start   = 1'b1;
                operand = ~op;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("done_pulse", o_done, 1);
        chk("done_valid", o_valid, 0);
        chk("done_busy", o_busy, 1);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk("idle_valid", o_valid, 0);
    endtask

    int          beats;
    logic [15:0] rx;

    initial begin
        rst = 1'b1; start = 1'b0; operand = '0; bit_ready = 1'b0; sel = 0;
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_idx", o_idx, 0);
        chk("rst_out", o_out, 0);
        chk("rst_last", o_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_scan(0, 16'hA5C3, -1, 1'b0, beats, rx);
        chk("lsb_beats", beats, 16);
        chk("lsb_rx", rx, 16'hA5C3);

        run_scan(1, 16'h8001, -1, 1'b0, beats, rx);
        chk("msb_beats", beats, 16);
        chk("msb_rx", rx, 16'h8001);

        run_scan(2, 16'h0013, -1, 1'b0, beats, rx);
        chk("ee13_beats", beats, 5);
        chk("ee13_rx", rx, 16'h0013);

        run_scan(2, 16'h0000, -1, 1'b0, beats, rx);
        chk("ee0_beats", beats, 1);
        chk("ee0_rx", rx, 16'h0000);

        run_scan(2, 16'h8000, -1, 1'b0, beats, rx);
        chk("ee8000_beats", beats, 16);
        chk("ee8000_rx", rx, 16'h8000);

        run_scan(0, 16'h5A3C, 5, 1'b0, beats, rx);
        chk("stall_beats", beats, 16);
        chk("stall_rx", rx, 16'h5A3C);

        run_scan(0, 16'h00F0, -1, 1'b1, beats, rx);
        chk("poke_beats", beats, 16);
        chk("poke_rx", rx, 16'h00F0);
        run_scan(0, 16'hFF0F, -1, 1'b0, beats, rx);
        chk("after_poke_rx", rx, 16'hFF0F);

        // Asynchronous reset in the middle of a scan.
        sel = 0; operand = 16'h1234; bit_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_idx", o_idx, 7);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_idx", o_idx, 0);
        chk("arst_out", o_out, 0);
        chk("arst_last", o_last, 0);
        #1 rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_rst_done", o_done, 0);
            chk("post_rst_busy", o_busy, 0);
        end
        run_scan(0, 16'hFFFF, -1, 1'b0, beats, rx);
        chk("ffff_beats", beats, 16);
        chk("ffff_rx", rx, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_sequencer.md
Name: bit_sequencer

Overview:
Parametrised, sequential successor to the 16-way combinational bit selector used by the iterative multiplier. It captures a WIDTH-bit operand on start, then presents one bit per accepted beat with its index, under a valid/ready handshake. Bit order is configurable, and an optional early exit stops the scan once no set bits remain. It sits between the operand register and the shift-add datapath of the multi-cycle multiplier.

Parameters:
WIDTH, 16, operand width in bits; must be ≥2.
IDXW, $clog2(WIDTH), width of the index output; derived, do not override.
MSB_FIRST, 0, 0 = scan index 0 upward; 1 = scan index WIDTH-1 downward.
EARLY_EXIT, 0, 1 = end the scan when all remaining unscanned bits are zero; honoured only when MSB_FIRST=0, ignored otherwise.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new scan; sampled only in IDLE.
operand  input  WIDTH  value to scan; captured on the accepted start edge.
bit_ready  input  1  consumer accepts the current bit when high together with bit_valid.
bit_valid  output  1  current bit_out/bit_idx/last are valid.
bit_out  output  1  value of shadow[bit_idx].
bit_idx  output  IDXW  index of the presented bit.
last  output  1  presented bit is the final beat of this scan.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- States: IDLE, RUN, DONE. All outputs are decoded from registered state only, with no combinational path from any input to any output.
- Reset (any time, including mid-scan): state=IDLE, shadow=0, idx=0; bit_valid=0, bit_out=0, bit_idx=0, last=0, busy=0, done=0. A scan in progress is abandoned, and no done pulse is produced.
- IDLE: bit_valid=0, busy=0. If start=1 at an edge: shadow<=operand, idx<=0 (MSB_FIRST=0) or WIDTH-1 (MSB_FIRST=1), go to RUN. First bit_valid is high in the following cycle (1-cycle start latency).
- RUN: bit_valid=1, busy=1, bit_out=shadow[idx], bit_idx=idx.
  - Beat accepted when bit_valid & bit_ready at an edge. Without acceptance, all outputs hold (stall of any length).
  - On an accepted non-last beat: idx steps by +1 (LSB-first) or -1 (MSB-first).
  - On an accepted last beat: go to DONE.
- last:
  - Normal: last=1 when idx==WIDTH-1 (LSB-first) or idx==0 (MSB-first).
  - EARLY_EXIT=1 and MSB_FIRST=0: last is also 1 when shadow bits above idx are all zero.
  - Consequence: operand==0 yields exactly one beat (idx 0, bit 0, last=1).
  - idx never wraps.
- DONE: lasts exactly one cycle. done=1, busy=1, bit_valid=0, then unconditionally go to IDLE.
- start outside IDLE (RUN or DONE) is ignored and is not queued. Back-to-back scans need start asserted in the cycle after done. Minimum period is beats+2 cycles.
- operand changes after capture have no effect on the scan in progress.
- bit_ready while bit_valid=0 has no effect.
- Beats per scan: WIDTH normally. With EARLY_EXIT, it is (index of highest set bit)+1, minimum 1.

Test Plan:
- WIDTH=16, MSB_FIRST=0, operand=16'hA5C3, bit_ready=1 held: start at cycle 0 -> bit_valid cycles 1..16, bit_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, last only at idx 15, done pulse cycle 17, busy low cycle 18.
- MSB_FIRST=1, operand=16'h8001: bit_idx sequence 15..0, bit_out=1 at idx 15 and idx 0 only, last at idx 0, done after 16 beats.
- EARLY_EXIT=1, operand=16'h0013 -> 5 beats, bits 1,1,0,0,1, last at idx 4, done next cycle; operand=0 -> 1 beat, idx 0, bit 0, last=1.
- Stall: bit_ready low for 3 cycles at idx 5 -> bit_idx stays 5 and bit_out stays stable throughout; scan resumes at idx 6 after bit_ready rises; total beats unchanged.
- start pulsed during RUN with a different operand, and during DONE -> ignored; original beat sequence unchanged; IDLE start afterwards captures the new operand.
- rst asserted asynchronously (between clock edges) at idx 7 -> all outputs 0 immediately, no done pulse; after release, a fresh start with operand=16'hFFFF gives 16 beats of 1.
